// File: rtl/psk_run_dispatcher_pkg.sv
// Shared DSP definitions for the PSK run dispatcher: channel encodings,
// channel-select mode encodings and NCO phase offsets.
package psk_run_dispatcher_pkg;

    localparam logic CHAN_I = 1'b0;
    localparam logic CHAN_Q = 1'b1;

    typedef enum logic [1:0] {
        MODE_I_ONLY = 2'd0,
        MODE_Q_ONLY = 2'd1,
        MODE_IQ     = 2'd2,
        MODE_IQ_ALT = 2'd3
    } mode_e;

    localparam logic [15:0] PHASE_I = 16'h0000;
    localparam logic [15:0] PHASE_Q = 16'h4000;

    // Whether the channel-select mode lets a channel emit records.
    function automatic logic chan_enabled(input logic [1:0] md, input logic chan);
        logic en;
        case (md)
            MODE_I_ONLY: en = (chan == CHAN_I);
            MODE_Q_ONLY: en = (chan == CHAN_Q);
            MODE_IQ:     en = 1'b1;
            MODE_IQ_ALT: en = 1'b1;
            default:     en = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/correlator.sv
// 1-bit correlator: adds +1 when the input matches the local code, -1
// otherwise, saturating at the signed range of VAL_W.
module correlator #(
    parameter int VAL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sig,
    input  logic                    code,
    output logic signed [VAL_W-1:0] acc
);
    localparam logic signed [VAL_W-1:0] ACC_MAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic signed [VAL_W-1:0] ACC_MIN = {1'b1, {(VAL_W-1){1'b0}}};
    localparam logic signed [VAL_W-1:0] ACC_ONE = VAL_W'(1);

    logic signed [VAL_W-1:0] r_acc;

    // Saturating signed accumulation of the sign-agreement product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (sig == code) begin
            if (r_acc != ACC_MAX) begin
                r_acc <= r_acc + ACC_ONE;
            end
        end else begin
            if (r_acc != ACC_MIN) begin
                r_acc <= r_acc - ACC_ONE;
            end
        end
    end

    assign acc = r_acc;
endmodule

// File: rtl/nco.sv
// Square-wave NCO: 16-bit phase accumulator, code is the MSB of accumulator
// plus a fixed phase offset.
module nco (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] freq_word,
    input  logic [15:0] phase_word,
    output logic        code
);
    logic [15:0] r_acc;
    logic [15:0] w_phase;

    // Phase accumulator advances by the frequency word every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 16'h0000;
        end else begin
            r_acc <= r_acc + freq_word;
        end
    end

    assign w_phase = r_acc + phase_word;
    assign code    = w_phase[15];
endmodule

// File: rtl/run_fifo.sv
// Synchronous record FIFO; a push on a full FIFO is accepted only when a pop
// happens in the same cycle.
module run_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == FULL_CNT);
    assign empty   = (r_count == '0);
    assign w_pop   = rd_en & ~empty;
    assign w_push  = wr_en & (~full | w_pop);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array; contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/psk_run_dispatcher.sv
// Integrates I/Q correlations of a 1-bit PSK input, tracks per-channel sign
// run lengths and dispatches {chan, sign, run} records through a FIFO.
module psk_run_dispatcher
    import psk_run_dispatcher_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int CNT_W      = 8,
    parameter int INT_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             sig,
    input  logic [15:0]      nco_word,
    input  logic [1:0]       mode,
    output logic [CNT_W+1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int REC_W = CNT_W + 2;
    localparam int IW    = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
    localparam logic [IW-1:0]           LAST_CNT = IW'(INT_LEN - 1);
    localparam logic [CNT_W-1:0]        RUN_MAX  = '1;
    localparam logic [CNT_W-1:0]        RUN_ONE  = CNT_W'(1);
    localparam logic signed [VAL_W-1:0] ACC_ZERO = '0;

    logic [IW-1:0]           r_int_cnt;
    logic                    w_dump;
    logic                    r_dump_d1;
    logic                    w_corr_rst;
    logic [15:0]             r_nco_word;
    logic [1:0]              r_mode;
    logic                    w_code_i;
    logic                    w_code_q;
    logic signed [VAL_W-1:0] w_acc_i;
    logic signed [VAL_W-1:0] w_acc_q;
    logic [1:0]              r_smp_sign;
    logic [1:0]              r_vld;
    logic [1:0]              r_prev;
    logic [CNT_W-1:0]        r_run [2];
    logic [1:0]              r_emit;
    logic [REC_W-1:0]        r_rec [2];
    logic                    r_emit_q_d;
    logic [REC_W-1:0]        r_rec_q_d;
    logic                    w_wr_en;
    logic [REC_W-1:0]        w_wr_data;
    logic                    w_rd_en;
    logic [REC_W-1:0]        w_rd_data;
    logic                    w_full;
    logic                    w_empty;
    logic                    r_overflow;

    assign w_dump     = (r_int_cnt == LAST_CNT);
    assign w_corr_rst = rst_in | r_dump_d1;

    // Integration period counter and dump-delay flag.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_int_cnt <= '0;
            r_dump_d1 <= 1'b0;
        end else begin
            r_int_cnt <= w_dump ? '0 : r_int_cnt + IW'(1);
            r_dump_d1 <= w_dump;
        end
    end

    // Configuration is captured only at period boundaries (and while in reset).
    always_ff @(posedge clk) begin
        if (rst_in || w_dump) begin
            r_nco_word <= nco_word;
            r_mode     <= mode;
        end
    end

    nco u_nco_i (
        .clk        (clk),
        .rst        (rst_in),
        .freq_word  (r_nco_word),
        .phase_word (PHASE_I),
        .code       (w_code_i)
    );

    nco u_nco_q (
        .clk        (clk),
        .rst        (rst_in),
        .freq_word  (r_nco_word),
        .phase_word (PHASE_Q),
        .code       (w_code_q)
    );

    correlator #(.VAL_W(VAL_W)) u_corr_i (
        .clk  (clk),
        .rst  (w_corr_rst),
        .sig  (sig),
        .code (w_code_i),
        .acc  (w_acc_i)
    );

    correlator #(.VAL_W(VAL_W)) u_corr_q (
        .clk  (clk),
        .rst  (w_corr_rst),
        .sig  (sig),
        .code (w_code_q),
        .acc  (w_acc_q)
    );

    // Correlation signs captured on the dump cycle; negative means sign 1.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_smp_sign <= 2'b00;
        end else if (w_dump) begin
            r_smp_sign <= {(w_acc_q < ACC_ZERO), (w_acc_i < ACC_ZERO)};
        end
    end

    // Per-channel run tracking; a sign change closes the previous run as a record.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_vld  <= 2'b00;
            r_prev <= 2'b00;
            r_emit <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                r_run[c] <= '0;
                r_rec[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                r_emit[c] <= 1'b0;
                if (r_dump_d1) begin
                    if (!r_vld[c]) begin
                        r_vld[c]  <= 1'b1;
                        r_prev[c] <= r_smp_sign[c];
                        r_run[c]  <= RUN_ONE;
                    end else if (r_smp_sign[c] == r_prev[c]) begin
                        if (r_run[c] != RUN_MAX) begin
                            r_run[c] <= r_run[c] + RUN_ONE;
                        end
                    end else begin
                        r_emit[c] <= chan_enabled(r_mode, (c == 0) ? CHAN_I : CHAN_Q);
                        r_rec[c]  <= {((c == 0) ? CHAN_I : CHAN_Q), r_prev[c], r_run[c]};
                        r_prev[c] <= r_smp_sign[c];
                        r_run[c]  <= RUN_ONE;
                    end
                end
            end
        end
    end

    // Q record waits one extra cycle so it always follows the I record.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_emit_q_d <= 1'b0;
            r_rec_q_d  <= '0;
        end else begin
            r_emit_q_d <= r_emit[1];
            r_rec_q_d  <= r_rec[1];
        end
    end

    assign w_wr_en   = r_emit[0] | r_emit_q_d;
    assign w_wr_data = r_emit[0] ? r_rec[0] : r_rec_q_d;
    assign w_rd_en   = out_ready & ~w_empty;

    run_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_run_fifo (
        .clk     (clk),
        .rst     (rst_in),
        .wr_en   (w_wr_en),
        .wr_data (w_wr_data),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Sticky drop flag; a pop in the same cycle frees room for the push.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_overflow <= 1'b0;
        end else if (w_wr_en && w_full && !w_rd_en) begin
            r_overflow <= 1'b1;
        end
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : w_rd_data;
    assign overflow  = r_overflow;
endmodule
